a_plus_b_round_robin_scheduler: RTL

Shares one `a + b` adder and one output stream among `n_ch` requester channels. Each channel presents an `a` operand stream and a `b` operand stream. A round-robin scheduler grants one channel per cycle, but only a channel with both operands valid. The sum is pushed, tagged with the channel index, into a 2-entry output buffer. The block sits between per-channel operand FIFOs and a single downstream sum consumer.

---
 rtl/a_plus_b_round_robin_scheduler_if.sv | 29 ++
 rtl/a_plus_b_round_robin_scheduler.sv | 101 ++++++++++
 2 files changed

// File: rtl/a_plus_b_round_robin_scheduler_if.sv
// rtl/a_plus_b_round_robin_scheduler_if.sv - operand request and sum output bundle
// Per-channel a/b operand streams in, one tagged sum stream out.
interface a_plus_b_round_robin_scheduler_if #(
   parameter int width = 8,
   parameter int n_ch  = 4
);
   localparam int id_w = $clog2(n_ch);

   logic [n_ch-1:0]       a_valid;
   logic [n_ch-1:0]       a_ready;
   logic [n_ch*width-1:0] a_data;
   logic [n_ch-1:0]       b_valid;
   logic [n_ch-1:0]       b_ready;
   logic [n_ch*width-1:0] b_data;
   logic                  sum_valid;
   logic                  sum_ready;
   logic [width-1:0]      sum_data;
   logic [id_w-1:0]       sum_id;

   modport master (
      output a_valid, a_data, b_valid, b_data, sum_ready,
      input  a_ready, b_ready, sum_valid, sum_data, sum_id
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, sum_ready,
      output a_ready, b_ready, sum_valid, sum_data, sum_id
   );
endinterface

// File: rtl/a_plus_b_round_robin_scheduler.sv
// rtl/a_plus_b_round_robin_scheduler.sv - round-robin shared a+b adder
// Grants one channel with both operands valid per cycle into a 2-entry tagged sum FIFO.
module a_plus_b_round_robin_scheduler #(
   parameter int width = 8,
   parameter int n_ch  = 4
) (
   input logic clk,
   input logic rst,
   a_plus_b_round_robin_scheduler_if.slave bus
);
   localparam int id_w = $clog2(n_ch);

   logic [n_ch-1:0]  eligible;
   logic [n_ch-1:0]  ready;
   logic [id_w-1:0]  ptr;
   logic [id_w-1:0]  idx;
   logic [id_w-1:0]  g;
   logic             found;
   logic             space;
   logic             grant;
   logic             push;
   logic             pop;
   logic [1:0]       count;
   logic             rd_sel;
   logic             wr_sel;
   logic [width-1:0] sum;
   logic [width-1:0] buf_data [2];
   logic [id_w-1:0]  buf_id [2];

   assign eligible = bus.a_valid & bus.b_valid;
   assign space    = (count < 2'd2);

   // Search upward from ptr; index arithmetic wraps because n_ch is a power of two.
   always_comb begin
      found = 1'b0;
      g     = '0;
      idx   = '0;
      for (int k = 0; k < n_ch; k++) begin
         idx = ptr + id_w'(k);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
   end

   assign grant = found & space & ~rst;

   always_comb begin
      ready = '0;
      if (grant) begin
         ready[g] = 1'b1;
      end
   end

   assign bus.a_ready = ready;
   assign bus.b_ready = ready;

   assign sum  = bus.a_data[g*width +: width] + bus.b_data[g*width +: width];
   assign push = grant;
   assign pop  = (count != 2'd0) & bus.sum_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         ptr    <= '0;
         rd_sel <= 1'b0;
         wr_sel <= 1'b0;
      end else begin
         if (push) begin
            wr_sel <= ~wr_sel;
            ptr    <= g + 1'b1;
         end
         if (pop) begin
            rd_sel <= ~rd_sel;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is cleared on reset only to keep the idle outputs X-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_id[0]   <= '0;
         buf_id[1]   <= '0;
      end else if (push) begin
         buf_data[wr_sel] <= sum;
         buf_id[wr_sel]   <= g;
      end
   end

   assign bus.sum_valid = (count != 2'd0);
   assign bus.sum_data  = buf_data[rd_sel];
   assign bus.sum_id    = buf_id[rd_sel];
endmodule
